mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-client arbiter directly upstream of the byte-serial memory controller. It accepts instruction-fetch word reads and load/store-buffer requests, grants one at a time, and holds the controller request stable until the controller's one-cycle `mc_ready`. It then routes the result back to the owning client. A pipeline flush drops an in-flight fetch result without disturbing the controller.

## Interface
- `LS_PRIORITY`, default 0: 0 = round-robin on a tie; 1 = load/store always wins a tie.
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global enable; when low, all state and outputs hold.
- `flush_in`  in  1  cancels the outstanding/in-flight fetch.
- `if_valid`  in  1  fetch request; held with `if_addr` until `if_ready` or flush.
- `if_addr`  in  32  fetch address; always a 32-bit read, len 3'b010.
- `if_ready`  out  1  one-cycle pulse: `if_data` valid.
- `if_data`  out  32  fetched word.
- `ls_valid`  in  1  load/store request; held with its fields until `ls_ready`.
- `ls_wr`  in  1  1 = store.
- `ls_addr`  in  32  byte address.
- `ls_len`  in  3  controller length code: [1:0] = 0/1/2 for byte/half/word; bit 2 = sign-extend.
- `ls_wdata`  in  32  store data.
- `ls_ready`  out  1  one-cycle pulse: access done, `ls_rdata` valid for loads.
- `ls_rdata`  out  32  load result, already extended by the controller.
- `mc_valid`  out  1  request to controller.
- `mc_wr`, `mc_addr`, `mc_len`, `mc_data`  out  1/32/3/32  request fields.
- `mc_ready`  in  1  controller done pulse.
- `mc_res`  in  32  controller result, valid only while `mc_ready`=1.

## Operation
- States: IDLE, IF_BUSY, LS_BUSY, IF_DROP. All transitions happen only on edges where `rdy_in`=1.
- **IDLE**
  - Eligible clients: `if_valid`=1 and `if_ready`=0 and `flush_in`=0 for fetch; `ls_valid`=1 and `ls_ready`=0 for load/store. A client whose ready pulse is high this cycle is not eligible, which prevents re-granting a request being retired.
  - One eligible client → grant it.
  - Both eligible → LS wins if `LS_PRIORITY`=1; otherwise the client not granted last time wins.
  - On grant, latch the fields into `mc_*` and set `mc_valid`=1. Fetch grants drive `mc_wr`=0, `mc_len`=3'b010, `mc_data`=0. Go to IF_BUSY or LS_BUSY and update last-grant.
- **IF_BUSY / LS_BUSY**
  - `mc_*` are held constant.
  - On `mc_ready`=1: register `mc_res` into `if_data` or `ls_rdata`, pulse the matching ready for 1 cycle, clear `mc_valid`, go to IDLE.
  - Stores also pulse `ls_ready`; `ls_rdata` is then don't-care.
- **Flush**
  - `flush_in`=1 in IF_BUSY with `mc_ready`=0 → IF_DROP.
  - `flush_in`=1 in IF_BUSY with `mc_ready`=1 → IDLE, no `if_ready`.
  - IF_DROP keeps `mc_valid` high until `mc_ready`, then goes to IDLE with no `if_ready`. Controller transactions are never aborted.
  - Flush never affects LS states or `ls_*` outputs.
- **Client side:** clients must not change request fields while waiting and must drop `valid` on the edge after they see `ready`. An `if_ready` pulse coinciding with `flush_in` is discarded by the fetch unit.

## Timing
- Reset values: `mc_valid`=0, `mc_wr`=0, `mc_addr`=0, `mc_len`=0, `mc_data`=0, `if_ready`=0, `if_data`=0, `ls_ready`=0, `ls_rdata`=0. State = IDLE; last-grant = LS, so fetch wins the first tie.
- Grant latency: a request eligible in cycle t gives `mc_valid`=1 in cycle t+1.
- Return latency: `mc_ready` in cycle r gives client ready in r+1 and `mc_valid`=0 in r+1.
- Back-to-back: the next grant is decided in cycle r+1, so `mc_valid` is high again in r+2. This leaves one idle cycle, matching the controller's post-ready cycle.
- `rdy_in`=0: all registers hold, including a pending ready pulse, which then lasts until the next enabled edge. `mc_ready` is sampled only when `rdy_in`=1.
- Asynchronous reset mid-transaction: return to reset values immediately. The controller is reset by the same event, so no in-flight result is expected afterward.

## Test plan
- Single fetch, `if_addr`=0x1000; controller model returns 0xDEADBEEF with `mc_ready` 4 cycles after `mc_valid` → `mc_len`=2, `mc_wr`=0; `if_ready` for 1 cycle with `if_data`=0xDEADBEEF; `mc_valid` low one cycle later.
- Byte store, `ls_addr`=0x30000, `ls_wdata`=0x41, `ls_len`=0 → `mc_wr`=1, `mc_data`=0x41; `ls_ready` pulses; `if_ready` stays 0.
- Fetch and load both asserted from reset, `LS_PRIORITY`=0 → grants alternate: IF first, then LS, then IF. Rerun with `LS_PRIORITY`=1 → LS is always granted first.
- Fetch granted, `flush_in` pulsed 1 cycle before `mc_ready`; result 0x12345678 → no `if_ready`; `mc_valid` stays high until `mc_ready`; a pending LS is granted on the following IDLE cycle.
- `rdy_in` held low for 3 cycles during LS_BUSY, with `mc_ready` ignored while low → all outputs unchanged; the transaction completes normally once `rdy_in` returns high.
- Assert `rst_in` low asynchronously mid-LS_BUSY → all outputs zero before the next clock edge; the first request after release is granted with normal latency.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Client and controller handshake bundle for the two-client memory arbiter.
// slave  = arbiter's view (takes client requests, issues controller requests).
// master = environment's view (fetch unit, load/store buffer, controller).
interface mem_arbiter_if;
  // instruction-fetch client
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  // load/store client
  logic        ls_valid;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [2:0]  ls_len;
  logic [31:0] ls_wdata;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  // memory controller
  logic        mc_valid;
  logic        mc_wr;
  logic [31:0] mc_addr;
  logic [2:0]  mc_len;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic [31:0] mc_res;

  modport slave (
    input  if_valid, if_addr, ls_valid, ls_wr, ls_addr, ls_len, ls_wdata,
           mc_ready, mc_res,
    output if_ready, if_data, ls_ready, ls_rdata,
           mc_valid, mc_wr, mc_addr, mc_len, mc_data
  );

  modport master (
    output if_valid, if_addr, ls_valid, ls_wr, ls_addr, ls_len, ls_wdata,
           mc_ready, mc_res,
    input  if_ready, if_data, ls_ready, ls_rdata,
           mc_valid, mc_wr, mc_addr, mc_len, mc_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (fetch / load-store) arbiter in front of the byte-serial memory
// controller. One request in flight; controller fields held until mc_ready.
// A flushed fetch is still run to completion on the controller, only its
// result is dropped.
module mem_arbiter #(
  parameter bit LS_PRIORITY = 1'b0  // 1: load/store always wins a tie
) (
  input  logic          clk_in,
  input  logic          rst_in,     // async, active low
  input  logic          rdy_in,     // global enable
  input  logic          flush_in,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_IF_BUSY, S_LS_BUSY, S_IF_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last_if, w_last_if;
  logic        r_mc_valid, w_mc_valid;
  logic        r_mc_wr, w_mc_wr;
  logic [31:0] r_mc_addr, w_mc_addr;
  logic [2:0]  r_mc_len, w_mc_len;
  logic [31:0] r_mc_data, w_mc_data;
  logic        r_if_ready, w_if_ready;
  logic [31:0] r_if_data, w_if_data;
  logic        r_ls_ready, w_ls_ready;
  logic [31:0] r_ls_rdata, w_ls_rdata;

  logic w_if_elig, w_ls_elig, w_grant_ls, w_grant_if;

  // A client whose ready pulse is still high is being retired: not eligible.
  assign w_if_elig  = bus.if_valid & ~r_if_ready & ~flush_in;
  assign w_ls_elig  = bus.ls_valid & ~r_ls_ready;
  // LS wins when alone, when prioritised, or when fetch had the last grant.
  assign w_grant_ls = w_ls_elig & (~w_if_elig | LS_PRIORITY | r_last_if);
  assign w_grant_if = w_if_elig & ~w_grant_ls;

  // State register; every transition waits for an enabled edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     r_state <= S_IDLE;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_ls)      w_state_nxt = S_LS_BUSY;
        else if (w_grant_if) w_state_nxt = S_IF_BUSY;
      end
      S_IF_BUSY: begin
        if (bus.mc_ready)  w_state_nxt = S_IDLE;
        else if (flush_in) w_state_nxt = S_IF_DROP;
      end
      S_LS_BUSY: if (bus.mc_ready) w_state_nxt = S_IDLE;
      S_IF_DROP: if (bus.mc_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs (hold by default,
  // ready pulses fall back to zero).
  always_comb begin
    w_last_if  = r_last_if;
    w_mc_valid = r_mc_valid;
    w_mc_wr    = r_mc_wr;
    w_mc_addr  = r_mc_addr;
    w_mc_len   = r_mc_len;
    w_mc_data  = r_mc_data;
    w_if_ready = 1'b0;
    w_if_data  = r_if_data;
    w_ls_ready = 1'b0;
    w_ls_rdata = r_ls_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_grant_ls) begin
          w_mc_valid = 1'b1;
          w_mc_wr    = bus.ls_wr;
          w_mc_addr  = bus.ls_addr;
          w_mc_len   = bus.ls_len;
          w_mc_data  = bus.ls_wdata;
          w_last_if  = 1'b0;
        end else if (w_grant_if) begin
          w_mc_valid = 1'b1;
          w_mc_wr    = 1'b0;
          w_mc_addr  = bus.if_addr;
          w_mc_len   = 3'b010;
          w_mc_data  = 32'h0;
          w_last_if  = 1'b1;
        end
      end
      S_IF_BUSY: begin
        if (bus.mc_ready) begin
          w_mc_valid = 1'b0;
          // a flush landing on the completion edge swallows the result
          if (!flush_in) begin
            w_if_ready = 1'b1;
            w_if_data  = bus.mc_res;
          end
        end
      end
      S_LS_BUSY: begin
        if (bus.mc_ready) begin
          w_mc_valid = 1'b0;
          w_ls_ready = 1'b1;
          w_ls_rdata = bus.mc_res;
        end
      end
      S_IF_DROP: if (bus.mc_ready) w_mc_valid = 1'b0;
      default: ;
    endcase
  end

  // Output/bookkeeping registers; rdy_in low freezes everything, ready pulses included.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_last_if  <= 1'b0;
      r_mc_valid <= 1'b0;
      r_mc_wr    <= 1'b0;
      r_mc_addr  <= 32'h0;
      r_mc_len   <= 3'b000;
      r_mc_data  <= 32'h0;
      r_if_ready <= 1'b0;
      r_if_data  <= 32'h0;
      r_ls_ready <= 1'b0;
      r_ls_rdata <= 32'h0;
    end else if (rdy_in) begin
      r_last_if  <= w_last_if;
      r_mc_valid <= w_mc_valid;
      r_mc_wr    <= w_mc_wr;
      r_mc_addr  <= w_mc_addr;
      r_mc_len   <= w_mc_len;
      r_mc_data  <= w_mc_data;
      r_if_ready <= w_if_ready;
      r_if_data  <= w_if_data;
      r_ls_ready <= w_ls_ready;
      r_ls_rdata <= w_ls_rdata;
    end
  end

  assign bus.mc_valid = r_mc_valid;
  assign bus.mc_wr    = r_mc_wr;
  assign bus.mc_addr  = r_mc_addr;
  assign bus.mc_len   = r_mc_len;
  assign bus.mc_data  = r_mc_data;
  assign bus.if_ready = r_if_ready;
  assign bus.if_data  = r_if_data;
  assign bus.ls_ready = r_ls_ready;
  assign bus.ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance u_dut0 and
// LS-priority instance u_dut1 sharing clock, reset, enable and flush.
module tb_mem_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_arbiter_if b0();
  mem_arbiter_if b1();

  mem_arbiter #(.LS_PRIORITY(1'b0)) u_dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .bus(b0));
  mem_arbiter #(.LS_PRIORITY(1'b1)) u_dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .bus(b1));

  always #5 clk_in = ~clk_in;

  // step past the next rising edge; outputs are sampled 1 time unit later
  task automatic tick;
    @(posedge clk_in); #1;
  endtask

  task automatic idle_inputs;
    b0.if_valid = 0; b0.if_addr = 0; b0.ls_valid = 0; b0.ls_wr = 0; b0.ls_addr = 0;
    b0.ls_len = 0; b0.ls_wdata = 0; b0.mc_ready = 0; b0.mc_res = 0;
    b1.if_valid = 0; b1.if_addr = 0; b1.ls_valid = 0; b1.ls_wr = 0; b1.ls_addr = 0;
    b1.ls_len = 0; b1.ls_wdata = 0; b1.mc_ready = 0; b1.mc_res = 0;
  endtask

  task automatic do_reset;
    rst_in = 0; rdy_in = 1; flush_in = 0; idle_inputs();
    tick(); tick();
    rst_in = 1;
  endtask

  task automatic test_reset;
    rst_in = 0; rdy_in = 1; flush_in = 0; idle_inputs();
    #1;
    n_chk++; if (b0.mc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mc_valid got %b want 0", b0.mc_valid); end
    n_chk++; if ({b0.mc_wr, b0.mc_addr, b0.mc_len, b0.mc_data} !== 68'h0) begin n_fail++; $display("FAIL reset_mc_fields got %h/%h/%h/%h want 0", b0.mc_wr, b0.mc_addr, b0.mc_len, b0.mc_data); end
    n_chk++; if ({b0.if_ready, b0.if_data} !== 33'h0) begin n_fail++; $display("FAIL reset_if got %b/%h want 0/0", b0.if_ready, b0.if_data); end
    n_chk++; if ({b0.ls_ready, b0.ls_rdata} !== 33'h0) begin n_fail++; $display("FAIL reset_ls got %b/%h want 0/0", b0.ls_ready, b0.ls_rdata); end
    tick(); tick();
    rst_in = 1;
  endtask

  task automatic test_single_fetch;
    b0.if_valid = 1; b0.if_addr = 32'h1000;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_wr, b0.mc_len} !== 5'b1_0_010) begin n_fail++; $display("FAIL fetch_grant valid/wr/len got %b/%b/%b want 1/0/010", b0.mc_valid, b0.mc_wr, b0.mc_len); end
    n_chk++; if ({b0.mc_addr, b0.mc_data} !== {32'h1000, 32'h0}) begin n_fail++; $display("FAIL fetch_fields addr/data got %h/%h want 1000/0", b0.mc_addr, b0.mc_data); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if ({b0.mc_valid, b0.if_ready} !== 2'b10) begin n_fail++; $display("FAIL fetch_hold cyc%0d mc_valid/if_ready got %b/%b want 1/0", i, b0.mc_valid, b0.if_ready); end
    end
    b0.mc_ready = 1; b0.mc_res = 32'hDEADBEEF;
    tick();
    n_chk++; if ({b0.if_ready, b0.mc_valid, b0.ls_ready} !== 3'b100) begin n_fail++; $display("FAIL fetch_done if_ready/mc_valid/ls_ready got %b/%b/%b want 1/0/0", b0.if_ready, b0.mc_valid, b0.ls_ready); end
    n_chk++; if (b0.if_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_data got %h want deadbeef", b0.if_data); end
    b0.mc_ready = 0; b0.if_valid = 0;
    tick();
    n_chk++; if ({b0.if_ready, b0.mc_valid} !== 2'b00) begin n_fail++; $display("FAIL fetch_pulse_end if_ready/mc_valid got %b/%b want 0/0", b0.if_ready, b0.mc_valid); end
  endtask

  task automatic test_byte_store;
    b0.ls_valid = 1; b0.ls_wr = 1; b0.ls_addr = 32'h30000; b0.ls_wdata = 32'h41; b0.ls_len = 3'b000;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_wr, b0.mc_len} !== 5'b1_1_000) begin n_fail++; $display("FAIL store_grant valid/wr/len got %b/%b/%b want 1/1/000", b0.mc_valid, b0.mc_wr, b0.mc_len); end
    n_chk++; if ({b0.mc_addr, b0.mc_data} !== {32'h30000, 32'h41}) begin n_fail++; $display("FAIL store_fields addr/data got %h/%h want 30000/41", b0.mc_addr, b0.mc_data); end
    tick();
    b0.mc_ready = 1; b0.mc_res = 32'h0;
    tick();
    n_chk++; if ({b0.ls_ready, b0.if_ready, b0.mc_valid} !== 3'b100) begin n_fail++; $display("FAIL store_done ls_ready/if_ready/mc_valid got %b/%b/%b want 1/0/0", b0.ls_ready, b0.if_ready, b0.mc_valid); end
    b0.mc_ready = 0; b0.ls_valid = 0; b0.ls_wr = 0;
    tick();
    n_chk++; if (b0.ls_ready !== 1'b0) begin n_fail++; $display("FAIL store_pulse_end got %b want 0", b0.ls_ready); end
  endtask

  task automatic test_round_robin;
    do_reset();
    b0.if_valid = 1; b0.if_addr = 32'h3000;
    b0.ls_valid = 1; b0.ls_wr = 0; b0.ls_addr = 32'h2000; b0.ls_len = 3'b110;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_addr} !== {1'b1, 32'h3000}) begin n_fail++; $display("FAIL rr_first_if got %b/%h want 1/3000", b0.mc_valid, b0.mc_addr); end
    b0.mc_ready = 1; b0.mc_res = 32'h11;
    tick();
    n_chk++; if ({b0.if_ready, b0.if_data} !== {1'b1, 32'h11}) begin n_fail++; $display("FAIL rr_if_done got %b/%h want 1/11", b0.if_ready, b0.if_data); end
    b0.mc_ready = 0; b0.if_addr = 32'h3004;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_addr, b0.mc_len} !== {1'b1, 32'h2000, 3'b110}) begin n_fail++; $display("FAIL rr_second_ls got %b/%h/%b want 1/2000/110", b0.mc_valid, b0.mc_addr, b0.mc_len); end
    b0.mc_ready = 1; b0.mc_res = 32'h22;
    tick();
    n_chk++; if ({b0.ls_ready, b0.ls_rdata} !== {1'b1, 32'h22}) begin n_fail++; $display("FAIL rr_ls_done got %b/%h want 1/22", b0.ls_ready, b0.ls_rdata); end
    b0.mc_ready = 0; b0.ls_addr = 32'h2004;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_addr} !== {1'b1, 32'h3004}) begin n_fail++; $display("FAIL rr_third_if got %b/%h want 1/3004", b0.mc_valid, b0.mc_addr); end
    b0.mc_ready = 1; b0.mc_res = 32'h33;
    tick();
    b0.mc_ready = 0; b0.if_valid = 0; b0.ls_valid = 0;
    tick();
    // true tie with fetch granted last: load/store must win
    b0.if_valid = 1; b0.if_addr = 32'h3008; b0.ls_valid = 1;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_addr} !== {1'b1, 32'h2004}) begin n_fail++; $display("FAIL rr_tie_ls got %b/%h want 1/2004", b0.mc_valid, b0.mc_addr); end
    b0.mc_ready = 1;
    tick();
    b0.mc_ready = 0; b0.if_valid = 0; b0.ls_valid = 0;
    tick();
  endtask

  task automatic test_ls_priority;
    do_reset();
    b1.if_valid = 1; b1.if_addr = 32'h3000;
    b1.ls_valid = 1; b1.ls_wr = 0; b1.ls_addr = 32'h2000; b1.ls_len = 3'b010;
    tick();
    n_chk++; if ({b1.mc_valid, b1.mc_addr} !== {1'b1, 32'h2000}) begin n_fail++; $display("FAIL pri_first_ls got %b/%h want 1/2000", b1.mc_valid, b1.mc_addr); end
    b1.mc_ready = 1; b1.mc_res = 32'h44;
    tick();
    n_chk++; if ({b1.ls_ready, b1.ls_rdata} !== {1'b1, 32'h44}) begin n_fail++; $display("FAIL pri_ls_done got %b/%h want 1/44", b1.ls_ready, b1.ls_rdata); end
    b1.mc_ready = 0; b1.if_valid = 0; b1.ls_valid = 0;
    tick();
    // tie with LS granted last: round-robin would pick fetch, priority keeps LS
    b1.if_valid = 1; b1.if_addr = 32'h300C; b1.ls_valid = 1; b1.ls_addr = 32'h200C;
    tick();
    n_chk++; if ({b1.mc_valid, b1.mc_addr} !== {1'b1, 32'h200C}) begin n_fail++; $display("FAIL pri_tie_ls got %b/%h want 1/200c", b1.mc_valid, b1.mc_addr); end
    b1.mc_ready = 1;
    tick();
    b1.mc_ready = 0; b1.if_valid = 0; b1.ls_valid = 0;
    tick();
  endtask

  task automatic test_flush;
    do_reset();
    b0.if_valid = 1; b0.if_addr = 32'h4000;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_addr} !== {1'b1, 32'h4000}) begin n_fail++; $display("FAIL flush_fetch_grant got %b/%h want 1/4000", b0.mc_valid, b0.mc_addr); end
    b0.ls_valid = 1; b0.ls_wr = 0; b0.ls_addr = 32'h5000; b0.ls_len = 3'b010;
    tick();
    flush_in = 1; b0.if_valid = 0;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_addr, b0.if_ready} !== {1'b1, 32'h4000, 1'b0}) begin n_fail++; $display("FAIL flush_hold mc_valid/addr/if_ready got %b/%h/%b want 1/4000/0", b0.mc_valid, b0.mc_addr, b0.if_ready); end
    flush_in = 0; b0.mc_ready = 1; b0.mc_res = 32'h12345678;
    tick();
    n_chk++; if ({b0.if_ready, b0.mc_valid, b0.ls_ready} !== 3'b000) begin n_fail++; $display("FAIL flush_no_ready if_ready/mc_valid/ls_ready got %b/%b/%b want 0/0/0", b0.if_ready, b0.mc_valid, b0.ls_ready); end
    b0.mc_ready = 0;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_addr} !== {1'b1, 32'h5000}) begin n_fail++; $display("FAIL flush_ls_grant got %b/%h want 1/5000", b0.mc_valid, b0.mc_addr); end
    b0.mc_ready = 1; b0.mc_res = 32'h77;
    tick();
    n_chk++; if ({b0.ls_ready, b0.ls_rdata, b0.if_ready} !== {1'b1, 32'h77, 1'b0}) begin n_fail++; $display("FAIL flush_ls_done got %b/%h/%b want 1/77/0", b0.ls_ready, b0.ls_rdata, b0.if_ready); end
    b0.mc_ready = 0; b0.ls_valid = 0;
    tick();
  endtask

  task automatic test_rdy_hold;
    do_reset();
    b0.ls_valid = 1; b0.ls_wr = 0; b0.ls_addr = 32'h6000; b0.ls_len = 3'b010;
    tick();
    n_chk++; if (b0.mc_valid !== 1'b1) begin n_fail++; $display("FAIL rdy_grant got %b want 1", b0.mc_valid); end
    rdy_in = 0; b0.mc_ready = 1; b0.mc_res = 32'hAAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if ({b0.mc_valid, b0.ls_ready, b0.mc_addr} !== {1'b1, 1'b0, 32'h6000}) begin n_fail++; $display("FAIL rdy_frozen cyc%0d got %b/%b/%h want 1/0/6000", i, b0.mc_valid, b0.ls_ready, b0.mc_addr); end
    end
    rdy_in = 1; b0.mc_ready = 0;
    tick();
    n_chk++; if ({b0.mc_valid, b0.ls_ready} !== 2'b10) begin n_fail++; $display("FAIL rdy_ignored_ready got %b/%b want 1/0", b0.mc_valid, b0.ls_ready); end
    b0.mc_ready = 1; b0.mc_res = 32'h55;
    tick();
    n_chk++; if ({b0.ls_ready, b0.ls_rdata, b0.mc_valid} !== {1'b1, 32'h55, 1'b0}) begin n_fail++; $display("FAIL rdy_done got %b/%h/%b want 1/55/0", b0.ls_ready, b0.ls_rdata, b0.mc_valid); end
    b0.mc_ready = 0; rdy_in = 0;
    tick(); tick();
    n_chk++; if (b0.ls_ready !== 1'b1) begin n_fail++; $display("FAIL rdy_pulse_hold got %b want 1", b0.ls_ready); end
    rdy_in = 1; b0.ls_valid = 0;
    tick();
    n_chk++; if ({b0.ls_ready, b0.mc_valid} !== 2'b00) begin n_fail++; $display("FAIL rdy_pulse_end got %b/%b want 0/0", b0.ls_ready, b0.mc_valid); end
  endtask

  task automatic test_async_reset;
    b0.ls_valid = 1; b0.ls_wr = 1; b0.ls_addr = 32'h7000; b0.ls_wdata = 32'h99; b0.ls_len = 3'b010;
    tick();
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_wr, b0.mc_data} !== {1'b1, 1'b1, 32'h99}) begin n_fail++; $display("FAIL arst_busy got %b/%b/%h want 1/1/99", b0.mc_valid, b0.mc_wr, b0.mc_data); end
    #2 rst_in = 0;
    #1;
    n_chk++; if ({b0.mc_valid, b0.mc_wr, b0.mc_addr, b0.mc_len, b0.mc_data} !== 69'h0) begin n_fail++; $display("FAIL arst_mc_zero got %b/%b/%h/%b/%h want 0", b0.mc_valid, b0.mc_wr, b0.mc_addr, b0.mc_len, b0.mc_data); end
    n_chk++; if ({b0.ls_ready, b0.ls_rdata, b0.if_ready, b0.if_data} !== 66'h0) begin n_fail++; $display("FAIL arst_client_zero got %b/%h/%b/%h want 0", b0.ls_ready, b0.ls_rdata, b0.if_ready, b0.if_data); end
    b0.ls_valid = 0; b0.ls_wr = 0;
    #1 rst_in = 1;
    b0.if_valid = 1; b0.if_addr = 32'h8000;
    tick();
    n_chk++; if ({b0.mc_valid, b0.mc_addr, b0.mc_wr} !== {1'b1, 32'h8000, 1'b0}) begin n_fail++; $display("FAIL arst_next_grant got %b/%h/%b want 1/8000/0", b0.mc_valid, b0.mc_addr, b0.mc_wr); end
    b0.mc_ready = 1; b0.mc_res = 32'h1;
    tick();
    n_chk++; if ({b0.if_ready, b0.if_data} !== {1'b1, 32'h1}) begin n_fail++; $display("FAIL arst_next_done got %b/%h want 1/1", b0.if_ready, b0.if_data); end
    b0.mc_ready = 0; b0.if_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_byte_store();
    test_round_robin();
    test_ls_priority();
    test_flush();
    test_rdy_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
